wishbone_reg_file: RTL and testbench

WISHBONE_REG_FILE -- requirements
Module: wishbone_reg_file

---
 rtl/wishbone_reg_file.sv | 192 +++++++++++++++++++
 tb/tb_wishbone_reg_file.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_reg_file.sv
// Wishbone-slave register file with per-byte writes, read-only window, programmable
// wait states and a hardware-side write port that wins same-edge collisions.
module wishbone_reg_file #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned DATA_OFFSET = 0,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RO_BASE     = 0,
  parameter int unsigned RO_COUNT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    adr_i,
  input  logic [DATA_WIDTH/8-1:0]  sel_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic                     ack_o,
  output logic                     err_o,
  input  logic                     hw_we,
  input  logic [$clog2(DEPTH)-1:0] hw_idx,
  input  logic [DATA_WIDTH-1:0]    hw_dat
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [NB-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic [ADDR_WIDTH-1:0] eff_adr;
  logic                  eff_we;
  logic [NB-1:0]         eff_sel;
  logic [DATA_WIDTH-1:0] eff_wdat;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [31:0]           idx_ext;
  logic [IW-1:0]         idx;
  logic                  in_range;
  logic                  ro_hit;
  logic                  hw_ok;
  logic                  hw_hit;
  logic                  bus_ok;
  logic                  bus_wr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  assign req = cyc_i & stb_i;

  // With zero wait states the commit happens on the capture edge, so decode the live bus.
  assign eff_adr  = (state_q == IDLE) ? adr_i : adr_q;
  assign eff_we   = (state_q == IDLE) ? we_i  : we_q;
  assign eff_sel  = (state_q == IDLE) ? sel_i : sel_q;
  assign eff_wdat = (state_q == IDLE) ? dat_i : wdat_q;

  assign idx_full = eff_adr - ADDR_WIDTH'(DATA_OFFSET);
  assign idx_ext  = 32'(idx_full);
  assign idx      = idx_full[IW-1:0];
  assign in_range = idx_ext < 32'(DEPTH);

  generate
    if (RO_COUNT == 0) begin : g_no_ro
      assign ro_hit = 1'b0;
    end else if (RO_BASE == 0) begin : g_ro_zero
      assign ro_hit = idx_ext < 32'(RO_COUNT);
    end else begin : g_ro
      assign ro_hit = (idx_ext >= 32'(RO_BASE)) && (idx_ext < 32'(RO_BASE + RO_COUNT));
    end

    if (DEPTH == (32'd1 << IW)) begin : g_hw_pow2
      assign hw_ok = 1'b1;
    end else begin : g_hw_chk
      assign hw_ok = 32'(hw_idx) < 32'(DEPTH);
    end
  endgenerate

  assign bus_ok   = in_range & ~(eff_we & ro_hit);
  assign hw_hit   = hw_we & hw_ok & (hw_idx == idx);
  assign old_word = mem[idx];

  always_comb begin
    merged = old_word;
    for (int unsigned k = 0; k < NB; k++) begin
      if (eff_sel[k]) merged[8*k +: 8] = eff_wdat[8*k +: 8];
    end
  end

  always_comb begin
    logic enter_term;
    enter_term = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdat_d     = rdat_q;
    bus_wr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d  = adr_i;
          we_d   = we_i;
          sel_d  = sel_i;
          wdat_d = dat_i;
          if (WAIT_STATES == 0) begin
            state_d    = TERM;
            enter_term = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d    = TERM;
          enter_term = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_term) begin
      ack_d  = bus_ok;
      err_d  = ~bus_ok;
      bus_wr = bus_ok & eff_we & ~rst;
      if (!bus_ok)     rdat_d = '0;
      else if (hw_hit) rdat_d = hw_dat;
      else if (eff_we) rdat_d = merged;
      else             rdat_d = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage is not reset; the later hw assignment overrides a same-index bus commit.
  always_ff @(posedge clk) begin
    if (bus_wr) mem[idx] <= merged;
    if (hw_we && hw_ok) mem[hw_idx] <= hw_dat;
  end

  assign dat_o = rdat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wishbone_reg_file.sv
// Directed bench: three register-file configurations driven from a vector table
// plus hand-written collision, back-to-back, abort and reset sequences.
module tb_wishbone_reg_file;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc [ND];
  logic        stb [ND];
  logic        we  [ND];
  logic [15:0] adr [ND];
  logic [1:0]  sel [ND];
  logic [15:0] dat_i [ND];
  logic [15:0] dat_o [ND];
  logic        ack [ND];
  logic        err [ND];
  logic        hw_we [ND];
  logic [9:0]  hw_idx [ND];
  logic [15:0] hw_dat [ND];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wishbone_reg_file u0 (
    .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(dat_i[0]), .dat_o(dat_o[0]),
    .ack_o(ack[0]), .err_o(err[0]), .hw_we(hw_we[0]), .hw_idx(hw_idx[0]),
    .hw_dat(hw_dat[0])
  );

  wishbone_reg_file #(
    .DATA_OFFSET(32'h100), .WAIT_STATES(0), .RO_BASE(4), .RO_COUNT(2)
  ) u1 (
    .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(dat_i[1]), .dat_o(dat_o[1]),
    .ack_o(ack[1]), .err_o(err[1]), .hw_we(hw_we[1]), .hw_idx(hw_idx[1]),
    .hw_dat(hw_dat[1])
  );

  wishbone_reg_file #(
    .WAIT_STATES(3)
  ) u2 (
    .clk(clk), .rst(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .adr_i(adr[2]), .sel_i(sel[2]), .dat_i(dat_i[2]), .dat_o(dat_o[2]),
    .ack_o(ack[2]), .err_o(err[2]), .hw_we(hw_we[2]), .hw_idx(hw_idx[2]),
    .hw_dat(hw_dat[2])
  );

  typedef struct {
    int          d;
    bit          w;
    logic [15:0] a;
    logic [1:0]  s;
    logic [15:0] wd;
    bit          eack;
    bit          eerr;
    logic [15:0] edat;
  } vec_t;

  function automatic int ws(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following termination.
  task automatic bus(input int d, input bit w, input logic [15:0] a, input logic [1:0] s,
                     input logic [15:0] wd, output bit t_ack, output bit t_err,
                     output logic [15:0] rd, output int lat);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_i[d] = wd;
    lat = -1; t_ack = 1'b0; t_err = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) begin
        lat = i; t_ack = ack[d]; t_err = err[d]; rd = dat_o[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("u%0d_term_one_cycle", d), {30'd0, ack[d], err[d]}, 32'd0);
  endtask

  // Zero-wait instance only: bus request and hw write land on the same edge.
  task automatic bus_hw(input bit w, input logic [15:0] a, input logic [15:0] wd,
                        input logic [9:0] hi, input logic [15:0] hd,
                        output bit t_ack, output bit t_err, output logic [15:0] rd);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = w; adr[1] = a; sel[1] = 2'b11; dat_i[1] = wd;
    hw_we[1] = 1'b1; hw_idx[1] = hi; hw_dat[1] = hd;
    @(posedge clk); #1;
    t_ack = ack[1]; t_err = err[1]; rd = dat_o[1];
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0; hw_we[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic hw_wr(input int d, input logic [9:0] i, input logic [15:0] v);
    hw_we[d] = 1'b1; hw_idx[d] = i; hw_dat[d] = v;
    @(posedge clk); #1;
    hw_we[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[$];
    bit          ta, te, any_term;
    logic [15:0] rd;
    int          lat;
    logic [5:0]  pat;

    tv.push_back('{0, 1'b1, 16'h0105, 2'b11, 16'hA533, 1'b1, 1'b0, 16'hA533});
    tv.push_back('{0, 1'b0, 16'h0105, 2'b11, 16'h0000, 1'b1, 1'b0, 16'hA533});
    tv.push_back('{0, 1'b1, 16'h0010, 2'b11, 16'h1234, 1'b1, 1'b0, 16'h1234});
    tv.push_back('{0, 1'b1, 16'h0010, 2'b01, 16'hFFFF, 1'b1, 1'b0, 16'h12FF});
    tv.push_back('{0, 1'b0, 16'h0010, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h12FF});
    tv.push_back('{0, 1'b1, 16'h0010, 2'b10, 16'hABCD, 1'b1, 1'b0, 16'hABFF});
    tv.push_back('{0, 1'b0, 16'h0400, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{0, 1'b1, 16'h03FF, 2'b11, 16'h5A5A, 1'b1, 1'b0, 16'h5A5A});
    tv.push_back('{0, 1'b1, 16'h0400, 2'b11, 16'h7777, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{0, 1'b0, 16'h03FF, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h5A5A});
    tv.push_back('{1, 1'b1, 16'h0100, 2'b11, 16'h1111, 1'b1, 1'b0, 16'h1111});
    tv.push_back('{1, 1'b0, 16'h0100, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h1111});
    tv.push_back('{1, 1'b0, 16'h00FF, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{1, 1'b0, 16'h0500, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{1, 1'b1, 16'h0105, 2'b11, 16'hDEAD, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{1, 1'b0, 16'h0105, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h5555});
    tv.push_back('{1, 1'b1, 16'h0104, 2'b01, 16'hDEAD, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{1, 1'b0, 16'h0104, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h4444});
    tv.push_back('{1, 1'b1, 16'h0106, 2'b11, 16'h6666, 1'b1, 1'b0, 16'h6666});
    tv.push_back('{1, 1'b1, 16'h0103, 2'b11, 16'h3333, 1'b1, 1'b0, 16'h3333});
    tv.push_back('{2, 1'b1, 16'h0020, 2'b11, 16'hC0DE, 1'b1, 1'b0, 16'hC0DE});
    tv.push_back('{2, 1'b0, 16'h0020, 2'b11, 16'h0000, 1'b1, 1'b0, 16'hC0DE});

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0;
      dat_i[d] = '0; hw_we[d] = 1'b0; hw_idx[d] = '0; hw_dat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("u%0d_reset_ack", d), {31'd0, ack[d]}, 32'd0);
      chk($sformatf("u%0d_reset_err", d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("u%0d_reset_dat", d), {16'd0, dat_o[d]}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    hw_wr(1, 10'd5, 16'h5555);
    hw_wr(1, 10'd4, 16'h4444);

    foreach (tv[i]) begin
      bus(tv[i].d, tv[i].w, tv[i].a, tv[i].s, tv[i].wd, ta, te, rd, lat);
      chk($sformatf("v%0d_ack", i), {31'd0, ta}, {31'd0, tv[i].eack});
      chk($sformatf("v%0d_err", i), {31'd0, te}, {31'd0, tv[i].eerr});
      chk($sformatf("v%0d_dat", i), {16'd0, rd}, {16'd0, tv[i].edat});
      chk($sformatf("v%0d_latency", i), lat, 1 + ws(tv[i].d));
    end

    // RO index 5: bus write errors while a same-edge hw write lands.
    bus_hw(1'b1, 16'h0105, 16'h1357, 10'd5, 16'h9999, ta, te, rd);
    chk("ro_hw_err", {30'd0, ta, te}, 32'd1);
    chk("ro_hw_dat", {16'd0, rd}, 32'd0);
    bus(1, 1'b0, 16'h0105, 2'b11, 16'h0, ta, te, rd, lat);
    chk("ro_hw_readback", {16'd0, rd}, 32'h9999);

    // Write collision on index 3: hw data stored, bus still acked.
    bus_hw(1'b1, 16'h0103, 16'h7777, 10'd3, 16'hBEEF, ta, te, rd);
    chk("wcol_ack", {30'd0, ta, te}, 32'd2);
    chk("wcol_dat", {16'd0, rd}, 32'hBEEF);
    bus(1, 1'b0, 16'h0103, 2'b11, 16'h0, ta, te, rd, lat);
    chk("wcol_readback", {16'd0, rd}, 32'hBEEF);

    // Read collision on index 2 returns the new hw value.
    bus(1, 1'b1, 16'h0102, 2'b11, 16'h0BAD, ta, te, rd, lat);
    bus_hw(1'b0, 16'h0102, 16'h0000, 10'd2, 16'h2222, ta, te, rd);
    chk("rcol_ack", {30'd0, ta, te}, 32'd2);
    chk("rcol_dat", {16'd0, rd}, 32'h2222);

    // Back-to-back reads with stb held on the zero-wait instance.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 16'h0100; sel[1] = 2'b11;
    pat[5] = ack[1];
    for (int i = 4; i >= 0; i--) begin
      @(posedge clk); #1;
      pat[i] = ack[1];
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    chk("b2b_ack_pattern", {26'd0, pat}, 32'b010101);
    chk("b2b_dat", {16'd0, dat_o[1]}, 32'h1111);
    @(posedge clk); #1;

    // Abort by dropping cyc in WAIT.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'h0020; sel[2] = 2'b11;
    dat_i[2] = 16'hDEAD;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    any_term = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any_term = any_term | ack[2] | err[2];
    end
    chk("abort_no_term", {31'd0, any_term}, 32'd0);
    bus(2, 1'b0, 16'h0020, 2'b11, 16'h0, ta, te, rd, lat);
    chk("abort_no_write", {16'd0, rd}, 32'hC0DE);

    // Reset in the middle of WAIT.
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'h0020; sel[2] = 2'b11;
    dat_i[2] = 16'h0BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ack_err", {30'd0, ack[2], err[2]}, 32'd0);
    chk("rst_mid_dat", {16'd0, dat_o[2]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus(2, 1'b0, 16'h0020, 2'b11, 16'h0, ta, te, rd, lat);
    chk("rst_mem_intact", {16'd0, rd}, 32'hC0DE);
    bus(0, 1'b0, 16'h0105, 2'b11, 16'h0, ta, te, rd, lat);
    chk("rst_mem_intact_u0", {16'd0, rd}, 32'hA533);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
